// File: rtl/cache_way_array_pkg.sv
// Shared geometry constants for one cache way.
// No logic; constants only.
// Not applicable.
package cache_way_array_pkg;
  // Width of one data SRAM bank; a line is built from LINELEN/SRAMLEN banks.
  localparam int SRAMLEN = 128;

  // Default cache geometry.
  localparam int DEF_PA_BITS   = 56;
  localparam int DEF_NUMLINES  = 512;
  localparam int DEF_LINELEN   = 256;
  localparam int DEF_TAGLEN    = 26;
  localparam int DEF_OFFSETLEN = 5;
  localparam int DEF_INDEXLEN  = 9;

  // Number of data banks needed for a line.
  function automatic int numBanks(input int lineLen);
    return lineLen / SRAMLEN;
  endfunction
endpackage

// File: rtl/mux2.sv
// Two-input select.
// Combinational, zero latency.
// No flow control.
module mux2 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);
  assign y = s ? d1 : d0;
endmodule

// File: rtl/ram1p1rwbe.sv
// Single-port synchronous RAM with per-byte write enables.
// One-cycle read latency, read-before-write on the same address.
// No flow control; ce=0 holds dout and blocks writes.
module ram1p1rwbe #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     ce,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         din,
  input  logic                     we,
  input  logic [WIDTH/8-1:0]       bwe,
  output logic [WIDTH-1:0]         dout
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Read the old word, then overwrite only the enabled bytes.
  always_ff @(posedge clk) begin
    if (ce) begin
      dout <= mem[addr];
      if (we) begin
        for (int i = 0; i < WIDTH/8; i++) begin
          if (bwe[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
        end
      end
    end
  end
endmodule

// File: rtl/ram1p1rwe.sv
// Single-port synchronous RAM with whole-word write enable.
// One-cycle read latency, read-before-write on the same address.
// No flow control; ce=0 holds dout and blocks writes.
module ram1p1rwe #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 26
) (
  input  logic                     clk,
  input  logic                     ce,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         din,
  input  logic                     we,
  output logic [WIDTH-1:0]         dout
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Read the old word, then optionally overwrite it.
  always_ff @(posedge clk) begin
    if (ce) begin
      dout <= mem[addr];
      if (we) mem[addr] <= din;
    end
  end
endmodule

// File: rtl/cache_way_array.sv
// One cache way: tag/data SRAMs, valid/dirty bits, hit detect, AND-stage way outputs.
// Array reads land one cycle after the CacheEn edge; output muxing is combinational on them.
// No flow control; CacheEn=0 freezes reads, writes and valid/dirty state.
module cache_way_array import cache_way_array_pkg::*; #(
  parameter int PA_BITS         = DEF_PA_BITS,
  parameter int NUMLINES        = DEF_NUMLINES,
  parameter int LINELEN         = DEF_LINELEN,
  parameter int TAGLEN          = DEF_TAGLEN,
  parameter int OFFSETLEN       = DEF_OFFSETLEN,
  parameter int INDEXLEN        = DEF_INDEXLEN,
  parameter bit READ_ONLY_CACHE = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 FlushStage,
  input  logic                 CacheEn,
  input  logic [INDEXLEN-1:0]  CacheSet,
  input  logic [PA_BITS-1:0]   PAdr,
  input  logic [LINELEN-1:0]   LineWriteData,
  input  logic [LINELEN/8-1:0] LineByteMask,
  input  logic                 SetValid,
  input  logic                 SetDirty,
  input  logic                 ClearDirty,
  input  logic                 SelWriteback,
  input  logic                 SelFlush,
  input  logic                 VictimWay,
  input  logic                 FlushWay,
  input  logic                 InvalidateCache,
  output logic [LINELEN-1:0]   ReadDataLineWay,
  output logic                 HitWay,
  output logic                 ValidWay,
  output logic                 DirtyWay,
  output logic [TAGLEN-1:0]    TagWay
);
  localparam int NUMBANKS  = numBanks(LINELEN);
  localparam int BANKBYTES = SRAMLEN / 8;

  logic [TAGLEN-1:0]   PAdrTag, ReadTag;
  logic [LINELEN-1:0]  ReadDataLine;
  logic [NUMLINES-1:0] ValidBits;
  logic SelTag, SelNonHit, SelData;
  logic SetValidWay, SetValidEN, DataWriteEN, Dirty;
  logic unusedSink;

  // Tag field sits directly above the set index.
  assign PAdrTag = PAdr[OFFSETLEN+INDEXLEN +: TAGLEN];

  mux2 #(.WIDTH(1)) selDataMux (.d0(HitWay), .d1(SelTag), .s(SelNonHit), .y(SelData));

  assign SetValidWay = SetValid & SelData;
  assign SetValidEN  = SetValidWay & ~FlushStage;

  ram1p1rwe #(.DEPTH(NUMLINES), .WIDTH(TAGLEN)) tagRam (
    .clk(clk), .ce(CacheEn), .addr(CacheSet), .din(PAdrTag), .we(SetValidEN), .dout(ReadTag)
  );

  generate
    if (READ_ONLY_CACHE) begin : gReadOnly
      assign SelTag      = VictimWay;
      assign SelNonHit   = SetValid;
      assign DataWriteEN = SetValidEN;
      assign Dirty       = 1'b0;
      // Write-path inputs have no meaning in an instruction cache.
      assign unusedSink  = ^{1'b0, PAdr, LineByteMask, FlushWay, SelFlush, SelWriteback,
                             SetDirty, ClearDirty};

      for (genvar k = 0; k < NUMBANKS; k++) begin : gBank
        ram1p1rwe #(.DEPTH(NUMLINES), .WIDTH(SRAMLEN)) dataRam (
          .clk(clk), .ce(CacheEn), .addr(CacheSet),
          .din(LineWriteData[SRAMLEN*k +: SRAMLEN]), .we(DataWriteEN),
          .dout(ReadDataLine[SRAMLEN*k +: SRAMLEN])
        );
      end
    end else begin : gWritable
      logic                 SetDirtyWay, ClearDirtyWay;
      logic [LINELEN/8-1:0] ByteMask;
      logic [NUMLINES-1:0]  DirtyBits;

      mux2 #(.WIDTH(1)) selTagMux (.d0(VictimWay), .d1(FlushWay), .s(SelFlush), .y(SelTag));
      assign SelNonHit     = (FlushWay & SelFlush) | SetValid | SelWriteback;
      assign SetDirtyWay   = SetDirty & SelData;
      assign ClearDirtyWay = ClearDirty & SelData;
      assign DataWriteEN   = (SetValidWay | SetDirtyWay) & ~FlushStage;
      // A fill replaces the whole line; a store only touches its bytes.
      assign ByteMask      = SetValidWay ? '1 : LineByteMask;
      // Offset bits of PAdr are not used by the way itself.
      assign unusedSink    = ^{1'b0, PAdr};

      for (genvar k = 0; k < NUMBANKS; k++) begin : gBank
        ram1p1rwbe #(.DEPTH(NUMLINES), .WIDTH(SRAMLEN)) dataRam (
          .clk(clk), .ce(CacheEn), .addr(CacheSet),
          .din(LineWriteData[SRAMLEN*k +: SRAMLEN]), .we(DataWriteEN),
          .bwe(ByteMask[BANKBYTES*k +: BANKBYTES]),
          .dout(ReadDataLine[SRAMLEN*k +: SRAMLEN])
        );
      end

      // Dirty array with registered read; set wins over clear.
      always_ff @(posedge clk) begin
        if (reset) begin
          DirtyBits <= '0;
          Dirty     <= 1'b0;
        end else if (CacheEn) begin
          Dirty <= DirtyBits[CacheSet];
          if ((SetDirtyWay | ClearDirtyWay) & ~FlushStage) DirtyBits[CacheSet] <= SetDirtyWay;
        end
      end
    end
  endgenerate

  // Valid array with registered read; invalidate beats a same-cycle fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      ValidBits <= '0;
      ValidWay  <= 1'b0;
    end else if (CacheEn) begin
      ValidWay <= ValidBits[CacheSet];
      if (InvalidateCache) ValidBits <= '0;
      else if (SetValidEN) ValidBits[CacheSet] <= 1'b1;
    end
  end

  assign HitWay          = ValidWay & (ReadTag == PAdrTag);
  assign TagWay          = SelTag ? ReadTag : '0;
  assign DirtyWay        = SelTag & Dirty & ValidWay;
  assign ReadDataLineWay = SelData ? ReadDataLine : '0;
endmodule

// File: tb/tb_cache_way_array.sv
// Directed bench for cache_way_array: writable and read-only builds side by side.
// Array-level reference model checked every cycle, plus literal spot checks.
// Inputs change 1ns after the rising edge; outputs are compared mid-cycle.
module tb_cache_way_array;
  localparam int PA = 40;

  logic clk = 1'b0;
  logic reset, FlushStage, CacheEn;
  logic [8:0]   CacheSet;
  logic [PA-1:0] PAdr;
  logic [255:0] LineWriteData;
  logic [31:0]  LineByteMask;
  logic SetValid, SetDirty, ClearDirty, SelWriteback, SelFlush, VictimWay, FlushWay, InvalidateCache;

  logic [255:0] rwData, roData;
  logic         rwHit, roHit, rwValid, roValid, rwDirty, roDirty;
  logic [25:0]  rwTag, roTag;

  int tests = 0;
  int fails = 0;
  bit checkOn = 1'b0;

  always #5 clk = ~clk;

  cache_way_array #(.PA_BITS(PA), .READ_ONLY_CACHE(1'b0)) dutRw (
    .clk(clk), .reset(reset), .FlushStage(FlushStage), .CacheEn(CacheEn), .CacheSet(CacheSet),
    .PAdr(PAdr), .LineWriteData(LineWriteData), .LineByteMask(LineByteMask), .SetValid(SetValid),
    .SetDirty(SetDirty), .ClearDirty(ClearDirty), .SelWriteback(SelWriteback), .SelFlush(SelFlush),
    .VictimWay(VictimWay), .FlushWay(FlushWay), .InvalidateCache(InvalidateCache),
    .ReadDataLineWay(rwData), .HitWay(rwHit), .ValidWay(rwValid), .DirtyWay(rwDirty), .TagWay(rwTag)
  );

  cache_way_array #(.PA_BITS(PA), .READ_ONLY_CACHE(1'b1)) dutRo (
    .clk(clk), .reset(reset), .FlushStage(FlushStage), .CacheEn(CacheEn), .CacheSet(CacheSet),
    .PAdr(PAdr), .LineWriteData(LineWriteData), .LineByteMask(LineByteMask), .SetValid(SetValid),
    .SetDirty(SetDirty), .ClearDirty(ClearDirty), .SelWriteback(SelWriteback), .SelFlush(SelFlush),
    .VictimWay(VictimWay), .FlushWay(FlushWay), .InvalidateCache(InvalidateCache),
    .ReadDataLineWay(roData), .HitWay(roHit), .ValidWay(roValid), .DirtyWay(roDirty), .TagWay(roTag)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (index 0 = writable, 1 = read-only) ----------------
  logic [25:0]  mTag  [2][512];
  logic [255:0] mData [2][512];
  bit           mValid[2][512];
  bit           mDirty[2][512];
  logic [25:0]  rTag [2];
  logic [255:0] rData[2];
  bit           rValid[2];
  bit           rDirty[2];

  function automatic logic [25:0] curTag();
    return PAdr[PA-1:14];
  endfunction

  function automatic logic mSelTag(input int b);
    return (b == 0 && SelFlush) ? FlushWay : VictimWay;
  endfunction

  function automatic logic mHit(input int b);
    return rValid[b] && (rTag[b] == curTag());
  endfunction

  function automatic logic mSelData(input int b);
    logic nonHit;
    nonHit = (b == 1) ? SetValid : (SetValid | SelWriteback | (SelFlush & FlushWay));
    return nonHit ? mSelTag(b) : mHit(b);
  endfunction

  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      logic sd, fill, store, dirtyWr;
      sd      = mSelData(b);
      fill    = SetValid & sd & ~FlushStage;
      store   = (b == 0) & SetDirty & sd & ~FlushStage;
      dirtyWr = (b == 0) & (SetDirty | ClearDirty) & sd & ~FlushStage;
      if (CacheEn) begin
        rTag[b]  = mTag[b][CacheSet];
        rData[b] = mData[b][CacheSet];
        if (!reset) begin
          rValid[b] = mValid[b][CacheSet];
          rDirty[b] = mDirty[b][CacheSet];
        end
        if (fill) mTag[b][CacheSet] = curTag();
        if (fill || store)
          for (int i = 0; i < 32; i++)
            if (fill || b == 1 || LineByteMask[i])
              mData[b][CacheSet][8*i +: 8] = LineWriteData[8*i +: 8];
        if (!reset) begin
          if (InvalidateCache) for (int s = 0; s < 512; s++) mValid[b][s] = 1'b0;
          else if (fill) mValid[b][CacheSet] = 1'b1;
          if (dirtyWr) mDirty[b][CacheSet] = SetDirty;
        end
      end
      if (reset) begin
        for (int s = 0; s < 512; s++) begin
          mValid[b][s] = 1'b0;
          mDirty[b][s] = 1'b0;
        end
        rValid[b] = 1'b0;
        rDirty[b] = 1'b0;
      end
    end
  end

  task automatic cmpBuild(input int b, input logic h, input logic v, input logic d,
                          input logic [25:0] t, input logic [255:0] dat);
    logic st;
    st = mSelTag(b);
    chk($sformatf("b%0d HitWay", b), h, mHit(b));
    chk($sformatf("b%0d ValidWay", b), v, rValid[b]);
    chk($sformatf("b%0d DirtyWay", b), d, (b == 0) ? (st & rDirty[b] & rValid[b]) : 1'b0);
    chk($sformatf("b%0d TagWay", b), t, st ? rTag[b] : 26'h0);
    chk($sformatf("b%0d ReadDataLineWay", b), dat, mSelData(b) ? rData[b] : 256'h0);
  endtask

  always @(negedge clk) begin
    if (checkOn) begin
      cmpBuild(0, rwHit, rwValid, rwDirty, rwTag, rwData);
      cmpBuild(1, roHit, roValid, roDirty, roTag, roData);
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [255:0] patA();
    logic [255:0] p;
    for (int i = 0; i < 32; i++) p[8*i +: 8] = 8'(8'h40 + i);
    return p;
  endfunction

  function automatic logic [255:0] patB();
    logic [255:0] p;
    for (int i = 0; i < 32; i++) p[8*i +: 8] = 8'(8'hC0 + i);
    return p;
  endfunction

  function automatic logic [255:0] preData(input int s);
    logic [31:0] w;
    w = 32'hD000_0000 | 32'(s);
    return {8{w}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    SetValid = 0; SetDirty = 0; ClearDirty = 0; SelWriteback = 0; SelFlush = 0;
    FlushWay = 0; InvalidateCache = 0; FlushStage = 0; LineByteMask = '0;
  endtask

  task automatic setAddr(input int s, input logic [25:0] t);
    CacheSet = 9'(s);
    PAdr     = {t, 9'(s), 5'b0};
  endtask

  logic [255:0] ab;
  int           setsT5[5] = '{9, 5, 7, 0, 511};
  logic [25:0]  tagsT5[5] = '{26'h0AB, 26'h123, 26'h0100007, 26'h0100000, 26'h01001FF};

  initial begin
    // bytes 4-7 from B, the rest from A
    ab = patA();
    for (int i = 4; i < 8; i++) ab[8*i +: 8] = 8'(8'hC0 + i);

    // reset state
    reset = 1; CacheEn = 0; quiet(); VictimWay = 1; setAddr(0, 26'h0); LineWriteData = '0;
    tick(); tick(); #1;
    chk("reset ValidWay rw", rwValid, 0);
    chk("reset HitWay rw", rwHit, 0);
    chk("reset DirtyWay rw", rwDirty, 0);
    chk("reset ValidWay ro", roValid, 0);
    chk("reset HitWay ro", roHit, 0);
    reset = 0;

    // give every set a known tag and line, then invalidate everything
    CacheEn = 1;
    for (int s = 0; s < 512; s++) begin
      quiet(); SetValid = 1; VictimWay = 1;
      setAddr(s, 26'h0100000 | 26'(s)); LineWriteData = preData(s);
      tick();
    end
    quiet(); InvalidateCache = 1; setAddr(0, 26'h0); tick();
    quiet(); checkOn = 1;

    // 1: fill set 5, read back
    quiet(); SetValid = 1; VictimWay = 1; setAddr(5, 26'h123); LineWriteData = patA(); tick();
    quiet(); tick(); #1;
    chk("t1 HitWay rw", rwHit, 1);
    chk("t1 ValidWay rw", rwValid, 1);
    chk("t1 data rw", rwData, patA());
    chk("t1 TagWay rw", rwTag, 26'h123);
    chk("t1 HitWay ro", roHit, 1);
    chk("t1 data ro", roData, patA());
    // CacheEn=0 holds outputs and ignores invalidate/fill
    CacheEn = 0; InvalidateCache = 1; SetValid = 1; setAddr(7, 26'h3FF); tick(); #1;
    chk("hold ValidWay rw", rwValid, 1);
    chk("hold TagWay rw", rwTag, 26'h123);
    CacheEn = 1; quiet(); setAddr(5, 26'h123); tick(); #1;
    chk("hold no invalidate rw", rwHit, 1);

    // 2: store hit to bytes 4-7
    quiet(); SetDirty = 1; VictimWay = 0; LineByteMask = 32'h0000_00F0; LineWriteData = patB();
    tick();
    quiet(); VictimWay = 1; tick(); #1;
    chk("t2 DirtyWay victim1 rw", rwDirty, 1);
    chk("t2 data rw", rwData, ab);
    chk("t2 HitWay rw", rwHit, 1);
    chk("t2 data ro", roData, patA());
    chk("t2 DirtyWay ro", roDirty, 0);
    VictimWay = 0; #1;
    chk("t2 DirtyWay victim0 rw", rwDirty, 0);
    chk("t2 TagWay victim0 rw", rwTag, 26'h0);

    // 3: squashed fill of set 7
    quiet(); SetValid = 1; VictimWay = 1; FlushStage = 1; setAddr(7, 26'h2AA); LineWriteData = patA();
    tick();
    quiet(); VictimWay = 1; SelWriteback = 1; tick(); #1;
    chk("t3 ValidWay rw", rwValid, 0);
    chk("t3 HitWay rw", rwHit, 0);
    chk("t3 old tag rw", rwTag, 26'h0100007);
    chk("t3 old data rw", rwData, preData(7));
    chk("t3 ValidWay ro", roValid, 0);

    // 4: flush writeback of dirty set 5, then clear dirty
    quiet(); SelFlush = 1; FlushWay = 1; VictimWay = 0; setAddr(5, 26'h0); tick(); #1;
    chk("t4 TagWay rw", rwTag, 26'h123);
    chk("t4 DirtyWay rw", rwDirty, 1);
    chk("t4 data rw", rwData, ab);
    chk("t4 TagWay ro", roTag, 26'h0);
    ClearDirty = 1; tick();
    ClearDirty = 0; tick(); #1;
    chk("t4 cleared DirtyWay rw", rwDirty, 0);
    chk("t4 still valid rw", rwValid, 1);

    // 5: invalidate at the same edge as a fill
    quiet(); SetValid = 1; VictimWay = 1; InvalidateCache = 1; setAddr(9, 26'h0AB);
    LineWriteData = patB(); tick();
    for (int j = 0; j < 5; j++) begin
      quiet(); VictimWay = 1; setAddr(setsT5[j], tagsT5[j]); tick(); #1;
      chk($sformatf("t5 HitWay rw set %0d", setsT5[j]), rwHit, 0);
      chk($sformatf("t5 HitWay ro set %0d", setsT5[j]), roHit, 0);
      chk($sformatf("t5 ValidWay rw set %0d", setsT5[j]), rwValid, 0);
    end

    // 6: reset in the middle of a fill
    quiet(); SetValid = 1; SetDirty = 1; VictimWay = 1; setAddr(5, 26'h123); LineWriteData = patA();
    tick();
    quiet(); tick(); #1;
    chk("t6 pre DirtyWay rw", rwDirty, 1);
    chk("t6 pre HitWay rw", rwHit, 1);
    quiet(); reset = 1; SetValid = 1; VictimWay = 1; setAddr(10, 26'h0CC); tick(); #1;
    chk("t6 reset ValidWay rw", rwValid, 0);
    chk("t6 reset DirtyWay rw", rwDirty, 0);
    chk("t6 reset ValidWay ro", roValid, 0);
    reset = 0; quiet(); setAddr(5, 26'h123); tick(); #1;
    chk("t6 set5 ValidWay rw", rwValid, 0);
    chk("t6 set5 HitWay rw", rwHit, 0);
    chk("t6 set5 DirtyWay rw", rwDirty, 0);
    setAddr(10, 26'h0CC); tick(); #1;
    chk("t6 set10 HitWay rw", rwHit, 0);
    chk("t6 set10 HitWay ro", roHit, 0);

    tick();
    checkOn = 0;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
